// File: rtl/qpd_decimator_pkg.sv
// Shared types and helpers for the QPD decimator: FSM state encoding and
// full-scale code detection for any sample width up to 32 bits.
package qpd_decimator_pkg;

  typedef enum logic [0:0] {
    StIdle,
    StAccum
  } state_e;

  function automatic logic signed [31:0] pos_full_scale(int unsigned width);
    return (32'sd1 <<< (width - 1)) - 32'sd1;
  endfunction

  function automatic logic signed [31:0] neg_full_scale(int unsigned width);
    return -(32'sd1 <<< (width - 1));
  endfunction

endpackage

// File: rtl/qpd_decimator_if.sv
// Sample and average bus of the QPD decimator; master drives raw samples,
// slave returns window averages.
interface qpd_decimator_if #(
  parameter int unsigned inputBitSize = 16
) ();

  logic signed [inputBitSize-1:0] XDIFF_in;
  logic signed [inputBitSize-1:0] YDIFF_in;
  logic signed [inputBitSize-1:0] SUM_in;
  logic                           in_valid;
  logic signed [inputBitSize-1:0] XDIFF;
  logic signed [inputBitSize-1:0] YDIFF;
  logic signed [inputBitSize-1:0] SUM;
  logic                           out_valid;
  logic                           clipped;

  modport master (
    output XDIFF_in, YDIFF_in, SUM_in, in_valid,
    input  XDIFF, YDIFF, SUM, out_valid, clipped
  );

  modport slave (
    input  XDIFF_in, YDIFF_in, SUM_in, in_valid,
    output XDIFF, YDIFF, SUM, out_valid, clipped
  );

endinterface

// File: rtl/decim_channel.sv
// One decimation channel: accumulates samples, emits floor(sum / 2^shift) when
// the window closes, and tracks whether any sample hit a full-scale code.
module decim_channel
  import qpd_decimator_pkg::*;
#(
  parameter int unsigned inputBitSize = 16,
  parameter int unsigned maxLog2Len   = 8
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           clear,
  input  logic                           sample_valid,
  input  logic                           window_last,
  input  logic [3:0]                     shift,
  input  logic signed [inputBitSize-1:0] sample,
  output logic signed [inputBitSize-1:0] avg,
  output logic                           clipped
);

  localparam int unsigned AccW = inputBitSize + maxLog2Len;

  logic signed [AccW-1:0] acc_q;
  logic signed [AccW-1:0] sum;
  logic signed [31:0]     sample_wide;
  logic                   clip_q;
  logic                   full_scale;

  always_comb begin
    sample_wide = 32'(sample);
    full_scale  = (sample_wide == pos_full_scale(inputBitSize)) ||
                  (sample_wide == neg_full_scale(inputBitSize));
    sum         = acc_q + AccW'(sample);
  end

  // The closing sample is folded in directly so the accumulator can restart at zero.
  always_ff @(posedge clk) begin
    if (!reset) begin
      acc_q   <= '0;
      clip_q  <= 1'b0;
      avg     <= '0;
      clipped <= 1'b0;
    end else if (clear) begin
      acc_q  <= '0;
      clip_q <= 1'b0;
    end else if (sample_valid) begin
      if (window_last) begin
        acc_q   <= '0;
        clip_q  <= 1'b0;
        avg     <= inputBitSize'(sum >>> shift);
        clipped <= clip_q | full_scale;
      end else begin
        acc_q  <= sum;
        clip_q <= clip_q | full_scale;
      end
    end
  end

endmodule

// File: rtl/qpd_decimator.sv
// QPD decimator top: window length register, sample counter and idle/accumulate
// FSM driving three identical averaging channels.
module qpd_decimator
  import qpd_decimator_pkg::*;
#(
  parameter int unsigned inputBitSize = 16,
  parameter int unsigned maxLog2Len   = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic [3:0]       log2_len,
  input  logic             len_update,
  qpd_decimator_if.slave   bus
);

  localparam int unsigned CntW = maxLog2Len + 1;

  state_e            state_q, state_d;
  logic [3:0]        len_q;
  logic [3:0]        len_clamped;
  logic [CntW-1:0]   count_q;
  logic [CntW-1:0]   last_idx;
  logic              clear;
  logic              accept;
  logic              window_last;
  logic              out_valid_q;
  logic [2:0]        clip;

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:  if (enable)  state_d = StAccum;
      StAccum: if (!enable) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // A length update aborts the window and swallows any coincident sample.
  always_comb begin
    clear       = (state_q == StIdle) || len_update;
    accept      = (state_q == StAccum) && bus.in_valid && !len_update;
    last_idx    = (CntW'(1) << len_q) - CntW'(1);
    window_last = (count_q == last_idx);
    len_clamped = (log2_len > 4'(maxLog2Len)) ? 4'(maxLog2Len) : log2_len;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= StIdle;
      len_q       <= '0;
      count_q     <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      out_valid_q <= accept && window_last;
      if (len_update) len_q <= len_clamped;
      if (clear) begin
        count_q <= '0;
      end else if (accept) begin
        count_q <= window_last ? '0 : count_q + CntW'(1);
      end
    end
  end

  decim_channel #(
    .inputBitSize (inputBitSize),
    .maxLog2Len   (maxLog2Len)
  ) u_x (
    .clk          (clk),
    .reset        (reset),
    .clear        (clear),
    .sample_valid (accept),
    .window_last  (window_last),
    .shift        (len_q),
    .sample       (bus.XDIFF_in),
    .avg          (bus.XDIFF),
    .clipped      (clip[0])
  );

  decim_channel #(
    .inputBitSize (inputBitSize),
    .maxLog2Len   (maxLog2Len)
  ) u_y (
    .clk          (clk),
    .reset        (reset),
    .clear        (clear),
    .sample_valid (accept),
    .window_last  (window_last),
    .shift        (len_q),
    .sample       (bus.YDIFF_in),
    .avg          (bus.YDIFF),
    .clipped      (clip[1])
  );

  decim_channel #(
    .inputBitSize (inputBitSize),
    .maxLog2Len   (maxLog2Len)
  ) u_s (
    .clk          (clk),
    .reset        (reset),
    .clear        (clear),
    .sample_valid (accept),
    .window_last  (window_last),
    .shift        (len_q),
    .sample       (bus.SUM_in),
    .avg          (bus.SUM),
    .clipped      (clip[2])
  );

  assign bus.out_valid = out_valid_q;
  assign bus.clipped   = |clip;

endmodule

// File: tb/tb_qpd_decimator.sv
// Directed bench for qpd_decimator: a window-level reference model checked every
// cycle, plus literal expectations for each scenario.
module tb_qpd_decimator;

  logic       clk;
  logic       reset;
  logic       enable;
  logic [3:0] log2_len;
  logic       len_update;

  int checks = 0;
  int errors = 0;

  qpd_decimator_if #(.inputBitSize(16)) bus ();

  qpd_decimator #(
    .inputBitSize (16),
    .maxLog2Len   (8)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .log2_len   (log2_len),
    .len_update (len_update),
    .bus        (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(string name, logic signed [31:0] act, logic signed [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: collects whole windows and averages them with plain arithmetic.
  int                 xs[$], ys[$], ss[$];
  logic               m_active;
  int                 m_len;
  logic               exp_valid;
  logic signed [15:0] exp_x, exp_y, exp_s;
  logic               exp_clip;

  function automatic logic signed [15:0] window_avg(int q[$], int l);
    longint s = 0;
    foreach (q[i]) s += q[i];
    s = s >>> l;
    return 16'(s);
  endfunction

  function automatic bit has_full(int q[$]);
    foreach (q[i]) if (q[i] == 32767 || q[i] == -32768) return 1'b1;
    return 1'b0;
  endfunction

  initial begin
    forever begin
      @(posedge clk);
      if (!reset) begin
        m_active = 1'b0;
        m_len = 0;
        xs.delete(); ys.delete(); ss.delete();
        exp_valid = 1'b0;
        exp_x = '0; exp_y = '0; exp_s = '0;
        exp_clip = 1'b0;
      end else begin
        exp_valid = 1'b0;
        if (len_update) begin
          m_len = (log2_len > 4'd8) ? 8 : int'(log2_len);
          xs.delete(); ys.delete(); ss.delete();
        end else if (!m_active) begin
          xs.delete(); ys.delete(); ss.delete();
        end else if (bus.in_valid) begin
          xs.push_back(int'(bus.XDIFF_in));
          ys.push_back(int'(bus.YDIFF_in));
          ss.push_back(int'(bus.SUM_in));
          if (xs.size() == (1 << m_len)) begin
            exp_x = window_avg(xs, m_len);
            exp_y = window_avg(ys, m_len);
            exp_s = window_avg(ss, m_len);
            exp_clip = has_full(xs) || has_full(ys) || has_full(ss);
            exp_valid = 1'b1;
            xs.delete(); ys.delete(); ss.delete();
          end
        end
        m_active = enable;
      end
      @(negedge clk);
      check("out_valid", 32'(bus.out_valid), 32'(exp_valid));
      check("XDIFF", 32'(bus.XDIFF), 32'(exp_x));
      check("YDIFF", 32'(bus.YDIFF), 32'(exp_y));
      check("SUM", 32'(bus.SUM), 32'(exp_s));
      check("clipped", 32'(bus.clipped), 32'(exp_clip));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_len(int l);
    len_update = 1'b1;
    log2_len = 4'(l);
    tick();
    len_update = 1'b0;
  endtask

  task automatic send(int x, int y, int s);
    bus.XDIFF_in = 16'(x);
    bus.YDIFF_in = 16'(y);
    bus.SUM_in = 16'(s);
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
  endtask

  task automatic pin(string tag, int x, int y, int s, int c);
    check({tag, "_valid"}, 32'(bus.out_valid), 1);
    check({tag, "_x"}, 32'(bus.XDIFF), x);
    check({tag, "_y"}, 32'(bus.YDIFF), y);
    check({tag, "_s"}, 32'(bus.SUM), s);
    check({tag, "_clip"}, 32'(bus.clipped), c);
  endtask

  initial begin
    reset = 1'b0;
    enable = 1'b0;
    log2_len = '0;
    len_update = 1'b0;
    bus.XDIFF_in = '0;
    bus.YDIFF_in = '0;
    bus.SUM_in = '0;
    bus.in_valid = 1'b0;
    tick();
    tick();
    check("rst_valid", 32'(bus.out_valid), 0);
    check("rst_x", 32'(bus.XDIFF), 0);
    check("rst_clip", 32'(bus.clipped), 0);
    reset = 1'b1;
    enable = 1'b1;
    tick();

    // L=2: 4,8,12,16 -> 10
    set_len(2);
    send(4, -1, 100);
    send(8, -1, 100);
    send(12, -2, 100);
    send(16, -2, 100);
    pin("t1", 10, -2, 100, 0);
    check("t1_model_x", 32'(exp_x), 10);
    tick();
    check("t1_pulse_end", 32'(bus.out_valid), 0);
    check("t1_hold_x", 32'(bus.XDIFF), 10);

    // L=1 with a sample coinciding with the update, which must be dropped
    len_update = 1'b1;
    log2_len = 4'd1;
    bus.XDIFF_in = 16'(1000);
    bus.in_valid = 1'b1;
    tick();
    len_update = 1'b0;
    bus.in_valid = 1'b0;
    send(-3, 5, 7);
    check("t2_no_early", 32'(bus.out_valid), 0);
    send(-2, 6, 8);
    pin("t2", -3, 5, 7, 0);
    check("t2_model_x", 32'(exp_x), -3);

    // L=3 with gaps; full-scale SUM in sample 5
    set_len(3);
    for (int i = 0; i < 8; i++) begin
      send(i, 0, (i == 4) ? 32767 : 0);
      if (i == 2) begin
        tick();
        tick();
      end
    end
    pin("t3a", 3, 0, 4095, 1);
    for (int i = 0; i < 8; i++) send(0, 0, 0);
    pin("t3b", 0, 0, 0, 0);

    // Idle holds outputs and ignores samples
    enable = 1'b0;
    tick();
    send(5, 5, 5);
    tick();
    check("idle_valid", 32'(bus.out_valid), 0);
    check("idle_hold_clip", 32'(bus.clipped), 0);
    enable = 1'b1;
    tick();

    // L=8, abort after two samples, oversize request clamps to 8
    set_len(8);
    send(1, 1, 1);
    send(1, 1, 1);
    set_len(15);
    check("t4_model_len", m_len, 8);
    for (int i = 0; i < 256; i++) begin
      if (i == 255) check("t4_no_early", 32'(bus.out_valid), 0);
      send(i - 128, 1, 100);
    end
    pin("t4", -1, 1, 100, 0);

    // L=0 pass-through, every other cycle
    set_len(0);
    begin
      int vals[4] = '{7, -32768, 32767, 0};
      foreach (vals[i]) begin
        send(vals[i], 3, vals[i]);
        pin("t5", vals[i], 3, vals[i], (vals[i] == 7 || vals[i] == 0) ? 0 : 1);
        tick();
        check("t5_gap", 32'(bus.out_valid), 0);
      end
    end

    // Reset during sample 3 of a 4-sample window
    set_len(2);
    send(9, 9, 9);
    send(9, 9, 9);
    reset = 1'b0;
    bus.XDIFF_in = 16'(9);
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    tick();
    reset = 1'b1;
    check("t6_rst_valid", 32'(bus.out_valid), 0);
    check("t6_rst_x", 32'(bus.XDIFF), 0);
    check("t6_rst_s", 32'(bus.SUM), 0);
    tick();
    check("t6_after_valid", 32'(bus.out_valid), 0);
    set_len(2);
    send(1, -4, 2);
    send(2, -4, 2);
    send(3, -4, 2);
    send(5, -5, 3);
    pin("t6", 2, -5, 2, 0);
    tick();
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/qpd_decimator.md
QPD_DECIMATOR -- requirements
Module: qpd_decimator

Interface
REQ-001 SHALL have parameter inputBitSize, default 16: width of the signed XDIFF/YDIFF/SUM samples.
REQ-002 SHALL have parameter maxLog2Len, default 8: largest averaging window, as log2 of the sample count.
REQ-003 SHALL have port clk, input, 1: the single clock; all logic on its rising edge.
REQ-004 SHALL have port reset, input, 1: synchronous, active-low reset.
REQ-005 SHALL have ports XDIFF_in, YDIFF_in, SUM_in, input, inputBitSize each: raw signed QPD samples from the ADC interface.
REQ-006 SHALL have port in_valid, input, 1: the three inputs are valid this cycle.
REQ-007 SHALL have port enable, input, 1: low holds the block idle.
REQ-008 SHALL have port log2_len, input, 4: requested window of 2^log2_len samples.
REQ-009 SHALL have port len_update, input, 1: single-cycle strobe that loads log2_len.
REQ-010 SHALL have ports XDIFF, YDIFF, SUM, output, inputBitSize each: window averages, consumed by tweezerController.
REQ-011 SHALL have port out_valid, output, 1: one-cycle pulse marking new averages.
REQ-012 SHALL have port clipped, output, 1: the last emitted window contained at least one full-scale sample.

Function
REQ-013 SHALL be a 2-state FSM: IDLE (enable low) and ACCUM (enable high); IDLE->ACCUM when enable rises; ACCUM->IDLE when enable falls.
REQ-014 In IDLE, SHALL clear the accumulators, sample counter and clip tracker, emit no out_valid, and hold XDIFF/YDIFF/SUM/clipped at their last values.
REQ-015 SHALL keep the active window length L in a register; len_update loads min(log2_len, maxLog2Len).
REQ-016 Accumulators SHALL be signed, inputBitSize+maxLog2Len bits wide, so no overflow is possible for any window length.
REQ-017 In ACCUM, each in_valid cycle SHALL add the sign-extended sample to each accumulator and increment the counter.
REQ-018 When the 2^L-th valid sample arrives, the next cycle SHALL present (accumulator+sample)>>>L (arithmetic shift, rounding toward minus infinity), truncated to inputBitSize.
REQ-019 That same cycle SHALL drive out_valid high for exactly one cycle, with outputs held until the next window completes.
REQ-020 On the window-completing cycle the accumulators SHALL reload to zero with no lost or double-counted sample; windows are back-to-back and non-overlapping.
REQ-021 With L=0, SHALL act as a registered pass-through: out_valid one cycle after every in_valid, outputs equal to the inputs.
REQ-022 clipped SHALL be set for a window if any sample of any channel equals the most-positive or most-negative code; it updates only with out_valid.
REQ-023 A len_update SHALL abort the current window, discarding the accumulators, counter and clip tracker, and emit no partial-window out_valid.
REQ-024 If len_update and in_valid coincide, the update SHALL win and that sample is discarded.
REQ-025 Cycles with in_valid low SHALL not change the accumulators or counter; gaps of any length are allowed.
REQ-026 Latency from the last sample of a window to out_valid SHALL be exactly 1 cycle.

Reset
REQ-027 While reset is low at a clock edge, the block SHALL force: FSM=IDLE, L=0, accumulators=0, counter=0, XDIFF=YDIFF=SUM=0, out_valid=0, clipped=0.
REQ-028 A reset mid-window SHALL discard the partial window, with no out_valid on or after the reset cycle.

Structure
REQ-029 The FSM state encodings and full-scale code constants SHALL live in the shared tweezer package; widths SHALL remain module parameters.
REQ-030 A sub-module decim_channel SHALL hold one accumulate/shift/clip channel, instantiated three times; the counter, FSM and L register live in the top level.

Verification
REQ-031 Bench SHALL cover L=2, XDIFF samples 4,8,12,16 on consecutive in_valid cycles -> one out_valid pulse one cycle after the 4th sample, XDIFF=10.
REQ-032 Bench SHALL cover L=1, XDIFF samples -3,-2 -> XDIFF=-3 (floor of -2.5), clipped=0.
REQ-033 Bench SHALL cover L=3, SUM=32767 in sample 5 of 8 -> clipped=1 with that out_valid; the next all-midscale window -> clipped=0.
REQ-034 Bench SHALL cover L=8, two samples fed then len_update with log2_len=15 -> no out_valid; L becomes 8; the next 256 samples of 100 -> SUM=100.
REQ-035 Bench SHALL cover L=0, in_valid asserted every other cycle -> out_valid pulses one cycle after each sample, values identical to the inputs.
REQ-036 Bench SHALL cover reset low during sample 3 of a 4-sample window -> all outputs 0 and no out_valid; after release with enable high, a fresh 4-sample window averages correctly.
